// File: rtl/triple_collector_pkg.sv
// Shared types and constants for the triple collector.
package triple_collector_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  typedef logic [1:0] fill_cnt_t;

  localparam int TRIPLE_LEN = 3;

endpackage

// File: rtl/triple_collector.sv
// Groups a serial valid/ready word stream into registered (a,b,c) triples.
// Optional macro TRIPLE_COLLECTOR_CNT_EN adds a saturating triple_cnt output.
module triple_collector
  import triple_collector_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [1:0]       fill_cnt
`ifdef TRIPLE_COLLECTOR_CNT_EN
  ,
  output logic [15:0]      triple_cnt
`endif
);

  localparam fill_cnt_t LAST_SLOT = fill_cnt_t'(TRIPLE_LEN - 1);

  state_e          state_q, state_d;
  fill_cnt_t       fill_q, fill_d;
  logic [WIDTH-1:0] slot_a_q, slot_a_d;
  logic [WIDTH-1:0] slot_b_q, slot_b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic            acc;
  logic            drn;

`ifdef TRIPLE_COLLECTOR_CNT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    slot_a_d = slot_a_q;
    slot_b_d = slot_b_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;

    // While FULL a new word may only enter if the held triple leaves this cycle.
    in_ready  = !flush && ((state_q == FILL) || out_ready);
    out_valid = !flush && (state_q == FULL);
    acc       = in_valid && in_ready;
    drn       = out_valid && out_ready;

    if (flush) begin
      state_d = FILL;
      fill_d  = '0;
      a_d     = '0;
      b_d     = '0;
      c_d     = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (acc) begin
            if (fill_q == '0) begin
              slot_a_d = in_data;
              fill_d   = fill_cnt_t'(1);
            end else if (fill_q != LAST_SLOT) begin
              slot_b_d = in_data;
              fill_d   = LAST_SLOT;
            end else begin
              a_d     = slot_a_q;
              b_d     = slot_b_q;
              c_d     = in_data;
              fill_d  = '0;
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (drn) begin
            state_d = FILL;
            if (acc) begin
              slot_a_d = in_data;
              fill_d   = fill_cnt_t'(1);
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

`ifdef TRIPLE_COLLECTOR_CNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (drn && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign triple_cnt = cnt_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      fill_q   <= '0;
      slot_a_q <= '0;
      slot_b_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      slot_a_q <= slot_a_d;
      slot_b_q <= slot_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
    end
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign c_out    = c_q;
  assign fill_cnt = fill_q;

endmodule

// File: tb/tb_triple_collector.sv
// Self-checking bench for triple_collector: directed cases plus a randomised
// stream checked by a queue-based scoreboard fed from a word-level model.
module tb_triple_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] a_out, b_out, c_out;
  logic [1:0] fill_cnt;
`ifdef TRIPLE_COLLECTOR_CNT_EN
  logic [15:0] triple_cnt;
`endif

  logic ready_set = 1'b1;
  logic rand_mode = 1'b0;
  logic rnd_ready = 1'b0;
  assign out_ready = rand_mode ? rnd_ready : ready_set;

  triple_collector #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .fill_cnt  (fill_cnt)
`ifdef TRIPLE_COLLECTOR_CNT_EN
    ,
    .triple_cnt(triple_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } triple_t;

  triple_t    exp_q[$];
  logic [7:0] part_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_drn   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Word-level model: every accepted word joins the partial list; three make a triple.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        part_q.delete();
        exp_q.delete();
        n_drn = 0;
      end else if (in_valid && in_ready) begin
        part_q.push_back(in_data);
        if (part_q.size() == 3) begin
          exp_q.push_back('{a: part_q[0], b: part_q[1], c: part_q[2]});
          part_q.delete();
        end
      end
    end
  end

  // Monitor: compares every presented-and-taken triple against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_drn++;
      if (exp_q.size() == 0) begin
        check("unexpected_triple", 32'd1, 32'd0);
      end else begin
        triple_t t;
        t = exp_q.pop_front();
        check("triple_a", a_out, t.a);
        check("triple_b", b_out, t.b);
        check("triple_c", c_out, t.c);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the word was accepted.
  task automatic drive_word(input logic [7:0] w);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_flush();
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    part_q.delete();
    exp_q.delete();
    n_drn = 0;
  endtask

  task automatic wait_drained();
    bit done = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0);
    end
    if (!done) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  always @(posedge clk) begin
    #2;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state and a single triple with out_ready high.
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_a", a_out, 8'd0);
    check("rst_b", b_out, 8'd0);
    check("rst_c", c_out, 8'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("fill_seq0", fill_cnt, 2'd0);
    drive_word(8'd10);
    check("fill_seq1", fill_cnt, 2'd1);
    drive_word(8'd20);
    check("fill_seq2", fill_cnt, 2'd2);
    drive_word(8'd30);
    in_valid = 1'b0;
    check("fill_seq3", fill_cnt, 2'd0);
    check("t1_valid", out_valid, 1'b1);
    idle(1);
    check("t1_valid_one_cycle", out_valid, 1'b0);
    check("t1_a_kept", a_out, 8'd10);

    // Back-pressure, hold, then drain and capture in the same cycle.
    ready_set = 1'b0;
    drive_word(8'd10);
    drive_word(8'd20);
    drive_word(8'd30);
    in_data = 8'd40;
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", in_ready, 1'b0);
      check("full_valid", out_valid, 1'b1);
      check("hold_a", a_out, 8'd10);
      check("hold_b", b_out, 8'd20);
      check("hold_c", c_out, 8'd30);
      @(posedge clk);
      #1;
    end
    ready_set = 1'b1;
    drive_word(8'd40);
    check("nobubble_fill", fill_cnt, 2'd1);
    check("nobubble_valid", out_valid, 1'b0);
    drive_word(8'd50);
    drive_word(8'd60);
    idle(2);

    // Flush a partial triple.
    drive_word(8'd1);
    drive_word(8'd2);
    pulse_flush();
    check("flush_fill", fill_cnt, 2'd0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_a", a_out, 8'd0);
    check("flush_b", b_out, 8'd0);
    check("flush_c", c_out, 8'd0);
    drive_word(8'd7);
    drive_word(8'd8);
    drive_word(8'd9);
    idle(2);

    // Asynchronous reset mid-fill and while FULL.
    drive_word(8'd5);
    in_valid = 1'b0;
    #2 async_reset();
    #1;
    check("arst_fill", fill_cnt, 2'd0);
    check("arst_a", a_out, 8'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready_set = 1'b0;
    drive_word(8'd1);
    drive_word(8'd2);
    drive_word(8'd3);
    in_valid = 1'b0;
    check("pre_arst_full", out_valid, 1'b1);
    #2 async_reset();
    #1;
    check("arst_full_valid", out_valid, 1'b0);
    check("arst_full_a", a_out, 8'd0);
    check("arst_full_b", b_out, 8'd0);
    check("arst_full_c", c_out, 8'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready_set = 1'b1;
    drive_word(8'd11);
    drive_word(8'd22);
    drive_word(8'd33);
    idle(2);
    check("arst_post_drained", exp_q.size(), 32'd0);

    // Randomised gaps on both sides over 300 words.
    pulse_flush();
    rand_mode = 1'b1;
    for (int w = 0; w < 300; w++) begin
      idle($urandom_range(0, 2));
      drive_word(8'(w));
    end
    wait_drained();
    rand_mode = 1'b0;
    idle(1);
    check("rand_triples", n_drn, 32'd100);
    check("rand_partial", part_q.size(), 32'd0);
`ifdef TRIPLE_COLLECTOR_CNT_EN
    check("triple_cnt", triple_cnt, 32'd100);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
